// File: rtl/rom_stream_loader_if.sv
// Bus bundle between the boot ROM loader and its surroundings: external ROM,
// download port to the ROM-image RAMs, CPU run-time address and status.
interface rom_stream_loader_if #(
  parameter int ADDR_W = 19,
  parameter int LOAD_W = 17,
  parameter int RUN_W  = 15
);
  logic              start;
  logic [RUN_W-1:0]  rom_ra;
  logic [7:0]        rom_d;
  logic [ADDR_W-1:0] rom_a;
  logic [LOAD_W-1:0] dl_addr;
  logic [7:0]        dl_data;
  logic              dl_we;
  logic              romtrans_done;
  logic [7:0]        load_sum;

  modport master (
    output start, rom_ra, rom_d,
    input  rom_a, dl_addr, dl_data, dl_we, romtrans_done, load_sum
  );

  modport slave (
    input  start, rom_ra, rom_d,
    output rom_a, dl_addr, dl_data, dl_we, romtrans_done, load_sum
  );
endinterface

// File: rtl/rom_stream_loader.sv
// Boot-time ROM loader: copies LOAD_WORDS bytes from the external ROM into the
// on-chip image RAMs, holds the CPUs in reset until done, then yields rom_a.
module rom_stream_loader #(
  parameter int ADDR_W     = 19,
  parameter int LOAD_W     = 17,
  parameter int LOAD_WORDS = 131072,
  parameter int RUN_W      = 15,
  parameter int WAIT_CYC   = 1
) (
  input  logic          clk_6144,
  input  logic          reset,
  rom_stream_loader_if.slave bus
);
  typedef enum logic [1:0] {FETCH, WRITE, DONE} state_t;

  localparam logic [LOAD_W-1:0] LAST_ADDR = LOAD_W'(LOAD_WORDS - 1);
  localparam logic [3:0]        WAIT_LAST = 4'(WAIT_CYC);

  state_t            r_state, w_next;
  logic [LOAD_W-1:0] r_dl_addr;
  logic [3:0]        r_wait_cnt;
  logic [7:0]        r_dl_data;
  logic [7:0]        r_acc;
  logic [7:0]        r_load_sum;
  logic              r_done;
  logic              w_sample, w_last, w_restart, w_we;

  always_ff @(posedge clk_6144) begin
    if (reset) r_state <= FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_sample  = 1'b0;
    w_last    = 1'b0;
    w_restart = 1'b0;
    w_we      = 1'b0;
    case (r_state)
      FETCH: if (r_wait_cnt == WAIT_LAST) begin
        w_sample = 1'b1;
        w_next   = WRITE;
      end
      WRITE: begin
        w_we   = 1'b1;
        w_last = (r_dl_addr == LAST_ADDR);
        w_next = w_last ? DONE : FETCH;
      end
      DONE: if (bus.start) begin
        w_restart = 1'b1;
        w_next    = FETCH;
      end
      default: w_next = FETCH;
    endcase
  end

  always_ff @(posedge clk_6144) begin
    if (reset) begin
      r_dl_addr  <= '0;
      r_wait_cnt <= '0;
      r_dl_data  <= '0;
      r_acc      <= '0;
      r_done     <= 1'b0;
    end else begin
      if (r_state == FETCH) begin
        if (w_sample) begin
          r_dl_data  <= bus.rom_d;
          r_acc      <= r_acc + bus.rom_d;
          r_wait_cnt <= '0;
        end else begin
          r_wait_cnt <= r_wait_cnt + 4'd1;
        end
      end
      if (w_we) begin
        if (w_last) r_done    <= 1'b1;
        else        r_dl_addr <= r_dl_addr + LOAD_W'(1);
      end
      if (w_restart) begin
        r_dl_addr <= '0;
        r_acc     <= '0;
        r_done    <= 1'b0;
      end
    end
  end

  // The checksum survives reset so the last completed load stays readable.
  always_ff @(posedge clk_6144) begin
    if (!reset && w_last) r_load_sum <= r_acc;
  end

  assign bus.rom_a         = r_done ? ADDR_W'(bus.rom_ra) : ADDR_W'(r_dl_addr);
  assign bus.dl_addr       = r_dl_addr;
  assign bus.dl_data       = r_dl_data;
  assign bus.dl_we         = w_we;
  assign bus.romtrans_done = r_done;
  assign bus.load_sum      = r_load_sum;
endmodule

// File: tb/tb_rom_stream_loader.sv
// Scoreboard bench: two loaders (one wait state / no wait state) fed by ROM models.
module tb_rom_stream_loader;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst1, mode0;

  rom_stream_loader_if #(.ADDR_W(19), .LOAD_W(5), .RUN_W(15)) b0();
  rom_stream_loader_if #(.ADDR_W(19), .LOAD_W(4), .RUN_W(15)) b1();

  rom_stream_loader #(.ADDR_W(19), .LOAD_W(5), .LOAD_WORDS(16), .RUN_W(15), .WAIT_CYC(1))
    u0 (.clk_6144(clk), .reset(rst0), .bus(b0));
  rom_stream_loader #(.ADDR_W(19), .LOAD_W(4), .LOAD_WORDS(16), .RUN_W(15), .WAIT_CYC(0))
    u1 (.clk_6144(clk), .reset(rst1), .bus(b1));

  // ROM models: mode0=0 -> addr+1, mode0=1 -> addr; second ROM is all 8'hFF
  assign b0.rom_d = mode0 ? b0.rom_a[7:0] : b0.rom_a[7:0] + 8'd1;
  assign b1.rom_d = 8'hFF;

  int checks = 0;
  int errors = 0;

  typedef struct {int addr; int data;} wr_t;
  wr_t q0[$];
  wr_t q1[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (b0.dl_we === 1'b1) begin
      chk("u0_we_while_done", b0.romtrans_done, 0);
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL u0_unexpected_write addr=%0d data=%0d expected no write", b0.dl_addr, b0.dl_data);
      end else begin
        e = q0.pop_front();
        chk("u0_wr_addr", b0.dl_addr, e.addr);
        chk("u0_wr_data", b0.dl_data, e.data);
      end
    end
  end

  always @(negedge clk) begin
    wr_t e;
    if (b1.dl_we === 1'b1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL u1_unexpected_write addr=%0d data=%0d expected no write", b1.dl_addr, b1.dl_data);
      end else begin
        e = q1.pop_front();
        chk("u1_wr_addr", b1.dl_addr, e.addr);
        chk("u1_wr_data", b1.dl_data, e.data);
      end
    end
  end

  task automatic wait_done0(input int bound, output int cyc);
    cyc = 0;
    while (b0.romtrans_done !== 1'b1 && cyc < bound) begin
      @(negedge clk);
      cyc++;
    end
    chk("u0_done_timeout", b0.romtrans_done, 1);
  endtask

  initial begin
    int cyc, first, last;
    rst0 = 1'b1; rst1 = 1'b1; mode0 = 1'b0;
    b0.start = 1'b0; b0.rom_ra = '0;
    b1.start = 1'b0; b1.rom_ra = '0;
    repeat (3) @(negedge clk);

    // no-wait-state loader, all-FF ROM: checksum wraps
    chk("u1_rst_addr", b1.dl_addr, 0);
    chk("u1_rst_we",   b1.dl_we, 0);
    chk("u1_rst_done", b1.romtrans_done, 0);
    for (int i = 0; i < 16; i++) q1.push_back('{i, 255});
    rst1 = 1'b0;
    cyc = 0; first = -1; last = -1;
    while (b1.romtrans_done !== 1'b1 && cyc < 100) begin
      @(negedge clk); cyc++;
      if (b1.dl_we === 1'b1) begin
        if (first < 0) first = cyc;
        else chk("u1_we_spacing", cyc - last, 2);
        last = cyc;
      end
    end
    chk("u1_first_we",   first, 1);
    chk("u1_done_cycle", cyc, 32);
    chk("u1_load_sum",   b1.load_sum, 8'hF0);

    // one-wait-state loader, rom_d = addr+1
    chk("u0_rst_addr", b0.dl_addr, 0);
    chk("u0_rst_we",   b0.dl_we, 0);
    chk("u0_rst_done", b0.romtrans_done, 0);
    chk("u0_rst_data", b0.dl_data, 0);
    chk("u0_rst_roma", b0.rom_a, 0);
    for (int i = 0; i < 16; i++) q0.push_back('{i, i + 1});
    rst0 = 1'b0;
    cyc = 0; first = -1; last = -1;
    while (b0.romtrans_done !== 1'b1 && cyc < 200) begin
      @(negedge clk); cyc++;
      if (b0.dl_we === 1'b1) begin
        if (first < 0) first = cyc;
        else chk("u0_we_spacing", cyc - last, 3);
        last = cyc;
      end
    end
    chk("u0_first_we",   first, 2);
    chk("u0_done_cycle", cyc, 48);
    chk("u0_load_sum",   b0.load_sum, 136);
    chk("u0_done_addr",  b0.dl_addr, 15);

    // rom_a follows rom_ra combinationally once done
    b0.rom_ra = 15'h1234;
    #1 chk("u0_run_roma_a", b0.rom_a, 19'h01234);
    b0.rom_ra = 15'h7ABC;
    #1 chk("u0_run_roma_b", b0.rom_a, 19'h07ABC);
    @(negedge clk);

    // pulsed reload with rom_d = addr
    mode0 = 1'b1;
    for (int i = 0; i < 16; i++) q0.push_back('{i, i});
    b0.start = 1'b1;
    @(negedge clk);
    b0.start = 1'b0;
    chk("u0_reload_done_low", b0.romtrans_done, 0);
    chk("u0_reload_addr0",    b0.dl_addr, 0);
    wait_done0(200, cyc);
    chk("u0_reload_len", cyc, 48);
    chk("u0_reload_sum", b0.load_sum, 120);

    // reset in the middle of a load
    mode0 = 1'b0;
    for (int i = 0; i < 7; i++) q0.push_back('{i, i + 1});
    b0.start = 1'b1;
    @(negedge clk);
    b0.start = 1'b0;
    cyc = 0;
    while (b0.dl_addr !== 5'd7 && cyc < 100) begin
      @(negedge clk); cyc++;
    end
    chk("u0_reach_addr7", b0.dl_addr, 7);
    rst0 = 1'b1;
    @(negedge clk);
    chk("u0_midrst_addr", b0.dl_addr, 0);
    chk("u0_midrst_we",   b0.dl_we, 0);
    chk("u0_midrst_done", b0.romtrans_done, 0);
    chk("u0_midrst_sum_kept", b0.load_sum, 120);
    for (int i = 0; i < 16; i++) q0.push_back('{i, i + 1});
    rst0 = 1'b0;
    wait_done0(200, cyc);
    chk("u0_midrst_sum", b0.load_sum, 136);

    // start held high: one reload per DONE entry, never mid-load
    mode0 = 1'b1;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 16; i++) q0.push_back('{i, i});
    b0.start = 1'b1;
    @(negedge clk);
    chk("u0_hold_restart", b0.romtrans_done, 0);
    wait_done0(200, cyc);
    chk("u0_hold_len1", cyc, 48);
    chk("u0_hold_sum1", b0.load_sum, 120);
    @(negedge clk);
    chk("u0_hold_reload",   b0.romtrans_done, 0);
    chk("u0_hold_reload_a", b0.dl_addr, 0);
    b0.start = 1'b0;
    wait_done0(200, cyc);
    chk("u0_hold_len2", cyc, 48);
    chk("u0_hold_sum2", b0.load_sum, 120);
    repeat (10) @(negedge clk);
    chk("u0_stays_done", b0.romtrans_done, 1);
    chk("u0_queue_empty", q0.size(), 0);
    chk("u1_queue_empty", q1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout actual=running expected=finished");
    $fatal(1, "watchdog");
  end
endmodule
